// File: rtl/ray_sphere_scheduler.sv
// Walks a scene sphere list for one ray, issuing one ENABLE/READY transaction per
// sphere to the intersection unit and keeping the nearest hit by squared distance.
module ray_sphere_scheduler #(
    parameter int MAX_SPHERES    = 64,
    parameter int IDX_W          = 6,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  START,
    input  logic [2:0][15:0]      ray_p0,
    input  logic [2:0][15:0]      ray_p1,
    input  logic                  BOUNDED,
    input  logic [3:0]            THRESHOLD,
    input  logic [IDX_W:0]        num_spheres,
    output logic                  scene_rd,
    output logic [IDX_W-1:0]      scene_addr,
    input  logic [3:0][15:0]      scene_data,
    output logic                  isect_ENABLE,
    output logic [3:0][15:0]      isect_sphere,
    output logic [2:0][15:0]      isect_p0,
    output logic [2:0][15:0]      isect_p1,
    output logic                  isect_BOUNDED,
    output logic [3:0]            isect_THRESHOLD,
    input  logic                  isect_READY,
    input  logic                  isect_COLLIDE,
    input  logic [2:0][15:0]      isect_pint0,
    input  logic [2:0][15:0]      isect_pint1,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  HIT,
    output logic [IDX_W-1:0]      hit_index,
    output logic [2:0][15:0]      hit_point,
    output logic [35:0]           hit_dist2,
    output logic                  TIMEOUT_ERR
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W:0] MAX_N = MAX_SPHERES[IDX_W:0];

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_WAIT, S_COMPARE, S_FINISH
    } state_t;

    state_t               r_state, w_next;
    logic [IDX_W:0]       r_n, r_i;
    logic [TMO_W-1:0]     r_tmo;
    logic [3:0][15:0]     r_sphere;
    logic [2:0][15:0]     r_p0, r_p1, r_pint0, r_pint1, r_hit_pt;
    logic                 r_bounded, r_col, r_hit, r_tmo_err;
    logic [3:0]           r_thr;
    logic [IDX_W-1:0]     r_hit_idx;
    logic [35:0]          r_dist;

    logic [IDX_W:0]       w_n, w_i_nxt;
    logic                 w_tmo_hit, w_use1, w_take;
    logic [35:0]          w_d0, w_d1, w_cd;
    logic [2:0][15:0]     w_cp;

    // Sum of squared 17-bit signed axis differences; each square fits in 34 bits.
    function automatic logic [35:0] dist2(input logic [2:0][15:0] a, input logic [2:0][15:0] b);
        logic signed [16:0] d;
        logic signed [33:0] de;
        logic [33:0]        sq;
        dist2 = '0;
        for (int k = 0; k < 3; k++) begin
            d     = $signed({a[k][15], a[k]}) - $signed({b[k][15], b[k]});
            de    = 34'(d);
            sq    = 34'(de * de);
            dist2 = dist2 + {2'b00, sq};
        end
    endfunction

    assign w_n       = (num_spheres > MAX_N) ? MAX_N : num_spheres;
    assign w_i_nxt   = r_i + 1'b1;
    assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
    assign w_d0      = dist2(r_pint0, r_p0);
    assign w_d1      = dist2(r_pint1, r_p0);
    // pint1 only displaces pint0 when strictly nearer, so pint0 wins ties
    assign w_use1    = (w_d1 < w_d0);
    assign w_cd      = w_use1 ? w_d1 : w_d0;
    assign w_cp      = w_use1 ? r_pint1 : r_pint0;
    assign w_take    = r_col && (!r_hit || (w_cd < r_dist));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (START) w_next = (w_n == '0) ? S_FINISH : S_FETCH;
            S_FETCH:   w_next = S_LOAD;
            S_LOAD:    w_next = S_ISSUE;
            S_ISSUE:   w_next = S_WAIT;
            S_WAIT:    if (isect_READY)   w_next = S_COMPARE;
                       else if (w_tmo_hit) w_next = S_FINISH;
            S_COMPARE: w_next = (w_i_nxt < r_n) ? S_FETCH : S_FINISH;
            S_FINISH:  w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        scene_rd     = 1'b0;
        isect_ENABLE = 1'b0;
        DONE         = 1'b0;
        BUSY         = 1'b0;
        case (r_state)
            S_FETCH:   begin scene_rd = 1'b1; BUSY = 1'b1; end
            S_ISSUE:   begin isect_ENABLE = 1'b1; BUSY = 1'b1; end
            S_LOAD, S_WAIT, S_COMPARE: BUSY = 1'b1;
            S_FINISH:  DONE = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_n       <= '0;
            r_i       <= '0;
            r_tmo     <= '0;
            r_sphere  <= '0;
            r_p0      <= '0;
            r_p1      <= '0;
            r_bounded <= 1'b0;
            r_thr     <= '0;
            r_col     <= 1'b0;
            r_pint0   <= '0;
            r_pint1   <= '0;
            r_hit     <= 1'b0;
            r_hit_idx <= '0;
            r_hit_pt  <= '0;
            r_dist    <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (START) begin
                    r_p0      <= ray_p0;
                    r_p1      <= ray_p1;
                    r_bounded <= BOUNDED;
                    r_thr     <= THRESHOLD;
                    r_n       <= w_n;
                    r_i       <= '0;
                    r_hit     <= 1'b0;
                    r_hit_idx <= '0;
                    r_hit_pt  <= '0;
                    r_dist    <= '0;
                    r_tmo_err <= 1'b0;
                end
                S_LOAD:  r_sphere <= scene_data;
                S_ISSUE: r_tmo    <= '0;
                S_WAIT: begin
                    if (isect_READY) begin
                        r_col   <= isect_COLLIDE;
                        r_pint0 <= isect_pint0;
                        r_pint1 <= isect_pint1;
                    end else if (w_tmo_hit) begin
                        r_tmo_err <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_COMPARE: begin
                    if (w_take) begin
                        r_hit     <= 1'b1;
                        r_hit_idx <= r_i[IDX_W-1:0];
                        r_hit_pt  <= w_cp;
                        r_dist    <= w_cd;
                    end
                    r_i <= w_i_nxt;
                end
                default: ;
            endcase
        end
    end

    assign scene_addr      = r_i[IDX_W-1:0];
    assign isect_sphere    = r_sphere;
    assign isect_p0        = r_p0;
    assign isect_p1        = r_p1;
    assign isect_BOUNDED   = r_bounded;
    assign isect_THRESHOLD = r_thr;
    assign HIT             = r_hit;
    assign hit_index       = r_hit_idx;
    assign hit_point       = r_hit_pt;
    assign hit_dist2       = r_dist;
    assign TIMEOUT_ERR     = r_tmo_err;

endmodule
